// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU.
//   AND, OR, ADD and SUB (and the undefined codes, which return 0) finish in
//   one cycle. MUL runs on a radix-2 shift-add engine for exactly WIDTH cycles.
//   A start/busy/valid handshake lets the pipeline stall while a multiply runs.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   start_i    request, accepted only when busy_o==0
//   ALUCtrl_i  000 AND, 001 OR, 010 ADD, 110 SUB, 111 MUL
//   data1_i    operand A (multiplicand)
//   data2_i    operand B (multiplier)
//   data_o     registered result, held until the next valid_o
//   zero_o     registered (data_o == 0)
//   busy_o     high while a MUL iterates
//   valid_o    one-cycle pulse per new result (stays high for back-to-back ops)
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             valid_o
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] single_res;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             is_mul;
  logic             last_iter;

  // Single-cycle operations; undefined codes yield 0 so zero_o reads 1.
  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept     = start_i & (state != S_MUL);
  assign is_mul     = (ALUCtrl_i == OP_MUL);
  assign last_iter  = (state == S_MUL) && (cnt == CNT_LAST);
  assign acc_next   = mplier[0] ? (acc + mcand) : acc;
  assign single_res = alu_op(ALUCtrl_i, data1_i, data2_i);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_next = is_mul ? S_MUL : S_DONE;
        else        state_next = S_IDLE;
      end
      S_MUL:   state_next = last_iter ? S_DONE : S_MUL;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    busy_o  = (state == S_MUL);
    valid_o = (state == S_DONE);
  end

  // Datapath: operand capture, shift-add iteration, result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      data_o <= '0;
      zero_o <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        acc    <= '0;
        mcand  <= data1_i;
        mplier <= data2_i;
        cnt    <= '0;
      end else begin
        data_o <= single_res;
        zero_o <= (single_res == '0);
      end
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      // The last iteration's partial product is folded in directly.
      if (last_iter) begin
        data_o <= acc_next;
        zero_o <= (acc_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] a, b;
  logic [31:0] data;
  logic        zero, busy, valid;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .ALUCtrl_i (ctrl),
    .data1_i   (a),
    .data2_i   (b),
    .data_o    (data),
    .zero_o    (zero),
    .busy_o    (busy),
    .valid_o   (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] exp;
    logic        ez;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue a MUL and follow it to completion. Optionally inject an ADD start
  // (with different operands) partway through, which must be ignored.
  task automatic run_mul(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input bit inject);
    int cycles, busy_cnt, valid_at, extra;
    cycles = 0; busy_cnt = 0; valid_at = -1; extra = 0;
    @(negedge clk);
    start = 1'b1; ctrl = 3'b111; a = x; b = y;
    @(posedge clk);
    while (cycles < 100 && valid_at < 0) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin start = 1'b0; a = 32'h1234_5678; b = 32'h9abc_def0; end
      if (inject && cycles == 10) begin start = 1'b1; ctrl = 3'b010; a = 32'd1; b = 32'd2; end
      if (inject && cycles == 11) start = 1'b0;
      if (busy) busy_cnt++;
      if (valid) begin
        valid_at = cycles;
        chk({name, "_data"}, data, exp);
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
      end
    end
    chk({name, "_valid_cycle"}, valid_at, 33);
    chk({name, "_busy_cycles"}, busy_cnt, 32);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid) extra++;
    end
    chk({name, "_extra_valid"}, extra, 0);
    chk({name, "_hold"}, data, exp);
  endtask

  initial begin
    vecs[0] = '{"add_7_5",     3'b010, 32'd7,        32'd5,        32'd12,       1'b0};
    vecs[1] = '{"sub_5_5",     3'b110, 32'd5,        32'd5,        32'd0,        1'b1};
    vecs[2] = '{"sub_0_1",     3'b110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vecs[3] = '{"and",         3'b000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    vecs[4] = '{"or",          3'b001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
    vecs[5] = '{"add_wrap",    3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[6] = '{"undef_011",   3'b011, 32'd9,        32'd9,        32'd0,        1'b1};
    vecs[7] = '{"undef_100",   3'b100, 32'd3,        32'd4,        32'd0,        1'b1};
    vecs[8] = '{"undef_101",   3'b101, 32'hFFFF0000, 32'h0000FFFF, 32'd0,        1'b1};

    start = 1'b0; ctrl = 3'b000; a = '0; b = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_data",  data, 32'd0);
    chk("rst_zero",  {31'd0, zero},  32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle vectors: valid one cycle after accept, then drops, data held.
    foreach (vecs[i]) begin
      @(negedge clk);
      start = 1'b1; ctrl = vecs[i].op; a = vecs[i].opa; b = vecs[i].opb;
      @(negedge clk);
      start = 1'b0;
      chk({vecs[i].name, "_valid"}, {31'd0, valid}, 32'd1);
      chk({vecs[i].name, "_data"},  data, vecs[i].exp);
      chk({vecs[i].name, "_zero"},  {31'd0, zero}, {31'd0, vecs[i].ez});
      @(negedge clk);
      chk({vecs[i].name, "_valid_drop"}, {31'd0, valid}, 32'd0);
      chk({vecs[i].name, "_hold"}, data, vecs[i].exp);
    end

    // Back-to-back AND then OR: valid stays high two consecutive cycles.
    @(negedge clk);
    start = 1'b1; ctrl = 3'b000; a = 32'h0000F0F0; b = 32'h0000FF00;
    @(negedge clk);
    chk("b2b_valid0", {31'd0, valid}, 32'd1);
    chk("b2b_data0",  data, 32'h0000F000);
    ctrl = 3'b001;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_valid1", {31'd0, valid}, 32'd1);
    chk("b2b_data1",  data, 32'h0000FFF0);
    @(negedge clk);
    chk("b2b_valid_drop", {31'd0, valid}, 32'd0);

    // MUL with a dropped ADD request mid-flight.
    run_mul("mul_3_fffffffe", 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, 1'b1);

    // Reset during MUL iteration 10 aborts at once.
    @(negedge clk);
    start = 1'b1; ctrl = 3'b111; a = 32'd100; b = 32'd200;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy",  {31'd0, busy},  32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_data",  data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_valid", {31'd0, valid}, 32'd0);

    run_mul("mul_6_7", 32'd6, 32'd7, 32'd42, 1'b0);

    // Undefined code then all-ones squared.
    @(negedge clk);
    start = 1'b1; ctrl = 3'b011; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("undef2_valid", {31'd0, valid}, 32'd1);
    chk("undef2_data",  data, 32'd0);
    chk("undef2_zero",  {31'd0, zero}, 32'd1);
    run_mul("mul_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_mul("mul_zero", 32'h00010000, 32'h00010000, 32'h00000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
